// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts one bubble per load-use dependency and counts the bubbles inserted.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              hold,
   input  logic [31:0]       id_instr,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic              id_R_Ibar_type,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemWrite,
   input  logic              id_MemRead,
   input  logic              id_Branch,
   input  logic              id_RegDst,
   input  logic [1:0]        id_Jump,
   input  logic [1:0]        id_ALUSrc,
   input  logic [1:0]        id_branch_type,
   input  logic [3:0]        id_ALU_ctrl,
   output logic              ex_R_Ibar_type,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemWrite,
   output logic              ex_MemRead,
   output logic              ex_Branch,
   output logic              ex_RegDst,
   output logic [1:0]        ex_Jump,
   output logic [1:0]        ex_ALUSrc,
   output logic [1:0]        ex_branch_type,
   output logic [3:0]        ex_ALU_ctrl,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [15:0]       ex_imm,
   output logic [4:0]        ex_shamt,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [4:0]        ex_wreg,
   output logic              ex_valid,
   output logic              hazard_stall,
   output logic [CNT_W-1:0]  bubble_count
);

   typedef struct packed {
      logic              rib;
      logic              m2r;
      logic              rw;
      logic              mw;
      logic              mr;
      logic              br;
      logic              rdst;
      logic [1:0]        jmp;
      logic [1:0]        alusrc;
      logic [1:0]        bt;
      logic [3:0]        alu;
      logic [DATA_W-1:0] rsd;
      logic [DATA_W-1:0] rtd;
      logic [DATA_W-1:0] pc4;
      logic [15:0]       imm;
      logic [4:0]        shamt;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd;
      logic [4:0]        wreg;
      logic              valid;
   } ex_t;

   ex_t             ex_q, ex_d, cap;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [5:0] op, fn;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       rs_used, rt_used, load_ex, loaduse;

   assign op    = id_instr[31:26];
   assign fn    = id_instr[5:0];
   assign id_rs = id_instr[25:21];
   assign id_rt = id_instr[20:16];
   assign id_rd = id_instr[15:11];

   always_comb begin
      rt_used = 1'b0;
      rs_used = 1'b1;
      if (op == 6'b000000) begin
         rt_used = (fn != 6'b001000);
         rs_used = !(fn == 6'b000000 || fn == 6'b000010 ||
                     fn == 6'b000011);
      end else begin
         rt_used = (op == 6'b000100 || op == 6'b000101 ||
                    op == 6'b101011);
         rs_used = !(op == 6'b000010 || op == 6'b000011 ||
                     op == 6'b001111);
      end
   end

   // Only loads that actually write a nonzero register can cause a hazard
   assign load_ex = ex_q.valid & ex_q.m2r & ex_q.rw & (ex_q.wreg != 5'd0);
   assign loaduse = load_ex &
                    ((rs_used & (ex_q.wreg == id_rs)) |
                     (rt_used & (ex_q.wreg == id_rt)));
   assign hazard_stall = loaduse & ~flush & ~hold;

   always_comb begin
      cap.rib    = id_R_Ibar_type;
      cap.m2r    = id_MemtoReg;
      cap.rw     = id_RegWrite;
      cap.mw     = id_MemWrite;
      cap.mr     = id_MemRead;
      cap.br     = id_Branch;
      cap.rdst   = id_RegDst;
      cap.jmp    = id_Jump;
      cap.alusrc = id_ALUSrc;
      cap.bt     = id_branch_type;
      cap.alu    = id_ALU_ctrl;
      cap.rsd    = id_rs_data;
      cap.rtd    = id_rt_data;
      cap.pc4    = id_pc4;
      cap.imm    = id_instr[15:0];
      cap.shamt  = id_instr[10:6];
      cap.rs     = id_rs;
      cap.rt     = id_rt;
      cap.rd     = id_rd;
      cap.valid  = 1'b1;
      if (id_Jump == 2'b11) cap.wreg = 5'd31;
      else if (id_RegDst)   cap.wreg = id_rt;
      else                  cap.wreg = id_rd;
   end

   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (flush) begin
         ex_d = '0;
      end else if (hold) begin
         ex_d = ex_q;
      end else if (loaduse) begin
         ex_d = '0;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
         ex_d = cap;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign ex_R_Ibar_type = ex_q.rib;
   assign ex_MemtoReg    = ex_q.m2r;
   assign ex_RegWrite    = ex_q.rw;
   assign ex_MemWrite    = ex_q.mw;
   assign ex_MemRead     = ex_q.mr;
   assign ex_Branch      = ex_q.br;
   assign ex_RegDst      = ex_q.rdst;
   assign ex_Jump        = ex_q.jmp;
   assign ex_ALUSrc      = ex_q.alusrc;
   assign ex_branch_type = ex_q.bt;
   assign ex_ALU_ctrl    = ex_q.alu;
   assign ex_rs_data     = ex_q.rsd;
   assign ex_rt_data     = ex_q.rtd;
   assign ex_pc4         = ex_q.pc4;
   assign ex_imm         = ex_q.imm;
   assign ex_shamt       = ex_q.shamt;
   assign ex_rs          = ex_q.rs;
   assign ex_rt          = ex_q.rt;
   assign ex_rd          = ex_q.rd;
   assign ex_wreg        = ex_q.wreg;
   assign ex_valid       = ex_q.valid;
   assign bubble_count   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomised and directed bench for id_ex_stage against an
// instruction-level model of the ID/EX register and hazard rules.
module tb_id_ex_stage;
   localparam int DW = 32;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;

   // ctl = {rib,m2r,rw,mw,mr,br,rdst,jmp[2],alusrc[2],bt[2],alu[4]}
   localparam logic [16:0] C_LW  = 17'b0_1_1_0_1_0_1_00_01_00_0010;
   localparam logic [16:0] C_ADD = 17'b1_0_1_0_0_0_0_00_00_00_0010;
   localparam logic [16:0] C_LUI = 17'b0_0_1_0_0_0_1_00_01_00_0111;
   localparam logic [16:0] C_JAL = 17'b0_0_1_0_0_0_0_11_00_00_0000;
   localparam logic [16:0] C_ORI = 17'b0_0_1_0_0_0_1_00_01_00_0100;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, hold = 1'b0;
   logic [31:0] id_instr = '0;
   logic [DW-1:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0;
   logic id_R_Ibar_type = 0, id_MemtoReg = 0, id_RegWrite = 0;
   logic id_MemWrite = 0, id_MemRead = 0, id_Branch = 0, id_RegDst = 0;
   logic [1:0] id_Jump = '0, id_ALUSrc = '0, id_branch_type = '0;
   logic [3:0] id_ALU_ctrl = '0;
   logic ex_R_Ibar_type, ex_MemtoReg, ex_RegWrite, ex_MemWrite;
   logic ex_MemRead, ex_Branch, ex_RegDst, ex_valid, hazard_stall;
   logic [1:0] ex_Jump, ex_ALUSrc, ex_branch_type;
   logic [3:0] ex_ALU_ctrl;
   logic [DW-1:0] ex_rs_data, ex_rt_data, ex_pc4;
   logic [15:0] ex_imm;
   logic [4:0] ex_shamt, ex_rs, ex_rt, ex_rd, ex_wreg;
   logic [CW-1:0] bubble_count;

   id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
      .id_instr(id_instr), .id_pc4(id_pc4),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_R_Ibar_type(id_R_Ibar_type), .id_MemtoReg(id_MemtoReg),
      .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite),
      .id_MemRead(id_MemRead), .id_Branch(id_Branch),
      .id_RegDst(id_RegDst), .id_Jump(id_Jump), .id_ALUSrc(id_ALUSrc),
      .id_branch_type(id_branch_type), .id_ALU_ctrl(id_ALU_ctrl),
      .ex_R_Ibar_type(ex_R_Ibar_type), .ex_MemtoReg(ex_MemtoReg),
      .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
      .ex_MemRead(ex_MemRead), .ex_Branch(ex_Branch),
      .ex_RegDst(ex_RegDst), .ex_Jump(ex_Jump), .ex_ALUSrc(ex_ALUSrc),
      .ex_branch_type(ex_branch_type), .ex_ALU_ctrl(ex_ALU_ctrl),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_pc4(ex_pc4),
      .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_valid(ex_valid),
      .hazard_stall(hazard_stall), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [16:0] ctl;
   } id_t;

   typedef struct packed {
      logic valid;
      id_t  f;
   } exm_t;

   id_t  cur;
   exm_t m;
   int   m_cnt;
   int   nvec = 0, nerr = 0;

   function automatic logic [31:0] r_ins(int rs, int rt, int rd,
                                         int sh, int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic id_t mk(logic [31:0] ins, logic [16:0] ctl);
      id_t r;
      r.instr = ins;
      r.pc4   = $urandom;
      r.rsd   = $urandom;
      r.rtd   = $urandom;
      r.ctl   = ctl;
      return r;
   endfunction

   function automatic bit uses_rt(logic [31:0] i);
      logic [5:0] op = i[31:26];
      if (op == 0) return i[5:0] != 6'h08;
      return op == 6'h04 || op == 6'h05 || op == 6'h2b;
   endfunction

   function automatic bit uses_rs(logic [31:0] i);
      logic [5:0] op = i[31:26];
      logic [5:0] fn = i[5:0];
      if (op == 0) return !(fn == 0 || fn == 2 || fn == 3);
      return !(op == 6'h02 || op == 6'h03 || op == 6'h0f);
   endfunction

   function automatic logic [4:0] m_wreg(id_t e);
      if (e.ctl[9:8] == 2'b11) return 5'd31;
      if (e.ctl[10]) return e.instr[20:16];
      return e.instr[15:11];
   endfunction

   function automatic bit m_loaduse();
      logic [4:0] w = m_wreg(m.f);
      bit ld = m.valid && m.f.ctl[15] && m.f.ctl[14] && w != 0;
      return ld && ((uses_rs(cur.instr) && w == cur.instr[25:21]) ||
                    (uses_rt(cur.instr) && w == cur.instr[20:16]));
   endfunction

   function automatic logic [17:0] obs_ctl();
      return {ex_valid, ex_R_Ibar_type, ex_MemtoReg, ex_RegWrite,
              ex_MemWrite, ex_MemRead, ex_Branch, ex_RegDst, ex_Jump,
              ex_ALUSrc, ex_branch_type, ex_ALU_ctrl};
   endfunction

   function automatic logic [17:0] exp_ctl();
      return m.valid ? {1'b1, m.f.ctl} : 18'd0;
   endfunction

   function automatic logic [136:0] obs_dat();
      return {ex_rs_data, ex_rt_data, ex_pc4, ex_imm, ex_shamt,
              ex_rs, ex_rt, ex_rd, ex_wreg};
   endfunction

   function automatic logic [136:0] exp_dat();
      return {m.f.rsd, m.f.rtd, m.f.pc4, m.f.instr[15:0],
              m.f.instr[10:6], m.f.instr[25:21], m.f.instr[20:16],
              m.f.instr[15:11], m_wreg(m.f)};
   endfunction

   task automatic drive(id_t d, logic fl, logic ho);
      cur = d;
      id_instr = d.instr;
      id_pc4 = d.pc4;
      id_rs_data = d.rsd;
      id_rt_data = d.rtd;
      {id_R_Ibar_type, id_MemtoReg, id_RegWrite, id_MemWrite, id_MemRead,
       id_Branch, id_RegDst, id_Jump, id_ALUSrc, id_branch_type,
       id_ALU_ctrl} = d.ctl;
      flush = fl;
      hold = ho;
      #1;
   endtask

   task automatic tick();
      bit lu = m_loaduse();
      @(posedge clk);
      if (flush) begin
         m = '0;
      end else if (hold) begin
         m = m;
      end else if (lu) begin
         m = '0;
         if (m_cnt < CMAX) m_cnt++;
      end else begin
         m.valid = 1'b1;
         m.f = cur;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m = '0;
      m_cnt = 0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      nvec++;
      if ({obs_ctl(), obs_dat(), bubble_count} !== '0) begin
         nerr++;
         $display("FAIL por_zero: got %h/%h cnt %0d want 0",
                  obs_ctl(), obs_dat(), bubble_count);
      end
      drive(mk(r_ins(1, 2, 3, 0, 32), C_ADD), 0, 0);
      tick();
      nvec++;
      if (obs_ctl() !== exp_ctl()) begin
         nerr++;
         $display("FAIL rst_cap: got %h want %h", obs_ctl(), exp_ctl());
      end
      #2;
      rst_n = 1'b0;
      m = '0;
      m_cnt = 0;
      #1;
      nvec++;
      if ({obs_ctl(), obs_dat(), bubble_count} !== '0) begin
         nerr++;
         $display("FAIL rst_async: got %h/%h cnt %0d want 0",
                  obs_ctl(), obs_dat(), bubble_count);
      end
      #1;
      rst_n = 1'b1;
      tick();
      // reset asserted while a load-use stall is pending
      drive(mk(i_ins(35, 9, 8, 4), C_LW), 0, 0);
      tick();
      drive(mk(r_ins(8, 11, 10, 0, 32), C_ADD), 0, 0);
      nvec++;
      if (hazard_stall !== 1'b1) begin
         nerr++;
         $display("FAIL rst_pre_stall: got %b want 1", hazard_stall);
      end
      do_reset();
      nvec++;
      if (hazard_stall !== 1'b0 || ex_valid !== 1'b0) begin
         nerr++;
         $display("FAIL rst_mid_stall: stall %b valid %b want 0 0",
                  hazard_stall, ex_valid);
      end
      tick();
      nvec++;
      if (obs_ctl() !== exp_ctl() || ex_valid !== 1'b1) begin
         nerr++;
         $display("FAIL rst_no_bubble: got %h want %h",
                  obs_ctl(), exp_ctl());
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(mk(i_ins(35, 9, 8, 0), C_LW), 0, 0);
      nvec++;
      if (hazard_stall !== 1'b0) begin
         nerr++;
         $display("FAIL lu_lw_stall: got %b want 0", hazard_stall);
      end
      tick();
      nvec++;
      if (obs_ctl() !== exp_ctl() || obs_dat() !== exp_dat()) begin
         nerr++;
         $display("FAIL lu_lw_ex: got %h want %h", obs_ctl(), exp_ctl());
      end
      drive(mk(r_ins(8, 11, 10, 0, 32), C_ADD), 0, 0);
      nvec++;
      if (hazard_stall !== 1'b1) begin
         nerr++;
         $display("FAIL lu_stall: got %b want 1", hazard_stall);
      end
      tick();
      nvec++;
      if (obs_ctl() !== 18'd0) begin
         nerr++;
         $display("FAIL lu_bubble: got %h want 0", obs_ctl());
      end
      nvec++;
      if (hazard_stall !== 1'b0) begin
         nerr++;
         $display("FAIL lu_stall_drop: got %b want 0", hazard_stall);
      end
      tick();
      nvec++;
      if (obs_ctl() !== exp_ctl() || ex_rs !== 5'd8 || ex_valid !== 1) begin
         nerr++;
         $display("FAIL lu_add: got %h rs %0d want %h rs 8",
                  obs_ctl(), ex_rs, exp_ctl());
      end
      nvec++;
      if (bubble_count !== CW'(1)) begin
         nerr++;
         $display("FAIL lu_count: got %0d want 1", bubble_count);
      end
   endtask

   task automatic test_no_false_stall();
      do_reset();
      drive(mk(i_ins(35, 9, 8, 0), C_LW), 0, 0);
      tick();
      drive(mk(i_ins(15, 8, 8, 16'h1234), C_LUI), 0, 0);
      nvec++;
      if (hazard_stall !== 1'b0) begin
         nerr++;
         $display("FAIL nfs_lui: got %b want 0", hazard_stall);
      end
      tick();
      drive(mk(i_ins(35, 9, 0, 0), C_LW), 0, 0);
      tick();
      drive(mk(r_ins(0, 0, 1, 0, 32), C_ADD), 0, 0);
      nvec++;
      if (hazard_stall !== 1'b0) begin
         nerr++;
         $display("FAIL nfs_r0: got %b want 0", hazard_stall);
      end
      tick();
   endtask

   task automatic test_jal();
      do_reset();
      drive(mk({6'd3, 26'h0100}, C_JAL), 0, 0);
      tick();
      nvec++;
      if (ex_wreg !== 5'd31 || ex_Jump !== 2'b11) begin
         nerr++;
         $display("FAIL jal_wreg: got %0d/%b want 31/11", ex_wreg, ex_Jump);
      end
      drive(mk(i_ins(35, 2, 31, 0), C_LW), 0, 0);
      tick();
      drive(mk(r_ins(31, 4, 3, 0, 32), C_ADD), 0, 0);
      nvec++;
      if (hazard_stall !== 1'b1) begin
         nerr++;
         $display("FAIL jal_ra_stall: got %b want 1", hazard_stall);
      end
      tick();
      tick();
      nvec++;
      if (obs_ctl() !== exp_ctl() || ex_valid !== 1'b1) begin
         nerr++;
         $display("FAIL jal_ra_add: got %h want %h", obs_ctl(), exp_ctl());
      end
   endtask

   task automatic test_flush();
      int c0;
      do_reset();
      drive(mk(i_ins(35, 9, 8, 0), C_LW), 0, 0);
      tick();
      c0 = m_cnt;
      drive(mk(r_ins(8, 11, 10, 0, 32), C_ADD), 1, 0);
      nvec++;
      if (hazard_stall !== 1'b0) begin
         nerr++;
         $display("FAIL fl_stall: got %b want 0", hazard_stall);
      end
      tick();
      nvec++;
      if (obs_ctl() !== 18'd0 || bubble_count !== CW'(c0)) begin
         nerr++;
         $display("FAIL fl_bubble: got %h cnt %0d want 0 cnt %0d",
                  obs_ctl(), bubble_count, c0);
      end
      drive(mk(i_ins(13, 1, 2, 5), C_ORI), 0, 0);
      tick();
      drive(mk(i_ins(13, 3, 4, 6), C_ORI), 1, 1);
      tick();
      nvec++;
      if (obs_ctl() !== 18'd0) begin
         nerr++;
         $display("FAIL fl_hold: got %h want 0", obs_ctl());
      end
   endtask

   task automatic test_hold();
      do_reset();
      drive(mk(i_ins(13, 1, 2, 16'h00ff), C_ORI), 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(mk(r_ins(3, 4, 5, 0, 32), C_ADD), 0, 1);
         tick();
         nvec++;
         if (ex_ALU_ctrl !== 4'b0100 || ex_valid !== 1'b1 ||
             obs_dat() !== exp_dat()) begin
            nerr++;
            $display("FAIL hold_%0d: alu %b valid %b want 0100 1",
                     i, ex_ALU_ctrl, ex_valid);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(mk(i_ins(35, 9, 8, 0), C_LW), 0, 0);
         tick();
         drive(mk(r_ins(8, 11, 10, 0, 32), C_ADD), 0, 0);
         tick();
         tick();
         nvec++;
         if (bubble_count !== CW'(m_cnt)) begin
            nerr++;
            $display("FAIL sat_%0d: got %0d want %0d", i, bubble_count, m_cnt);
         end
      end
      nvec++;
      if (bubble_count !== CW'(3)) begin
         nerr++;
         $display("FAIL sat_final: got %0d want 3", bubble_count);
      end
   endtask

   task automatic test_random();
      bit lu;
      logic [31:0] ins;
      logic [16:0] ctl;
      int a, b, c;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         a = $urandom_range(0, 3);
         b = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         ctl = 17'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2: begin ins = i_ins(35, a, b, $urandom); ctl = C_LW; end
            3: ins = r_ins(a, b, c, $urandom_range(0, 31), 32);
            4: ins = r_ins(a, b, c, $urandom_range(0, 31),
                           $urandom_range(0, 3));
            5: ins = r_ins(a, b, c, 0, 8);
            6: ins = i_ins(43, a, b, $urandom);
            7: ins = i_ins($urandom_range(4, 5), a, b, $urandom);
            8: ins = i_ins(15, a, b, $urandom);
            default: ins = {($urandom_range(0, 1) ? 6'd2 : 6'd3), 5'(a),
                            5'(b), 16'($urandom)};
         endcase
         drive(mk(ins, ctl), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) == 0));
         lu = m_loaduse() && !flush && !hold;
         nvec++;
         if (hazard_stall !== lu) begin
            nerr++;
            $display("FAIL rnd_stall@%0d: got %b want %b", i, hazard_stall, lu);
         end
         tick();
         nvec++;
         if (obs_ctl() !== exp_ctl() ||
             (m.valid && obs_dat() !== exp_dat()) ||
             bubble_count !== CW'(m_cnt)) begin
            nerr++;
            $display("FAIL rnd_ex@%0d: ctl %h cnt %0d want %h cnt %0d",
                     i, obs_ctl(), bubble_count, exp_ctl(), m_cnt);
         end
      end
   endtask

   initial begin
      m = '0;
      m_cnt = 0;
      cur = '0;
      #3;
      test_reset_por_release();
      test_reset();
      test_load_use();
      test_no_false_stall();
      test_jal();
      test_flush();
      test_hold();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   task automatic test_reset_por_release();
      nvec++;
      if (ex_valid !== 1'b0 || bubble_count !== '0) begin
         nerr++;
         $display("FAIL por_in_reset: valid %b cnt %0d want 0 0",
                  ex_valid, bubble_count);
      end
      #4;
      rst_n = 1'b1;
   endtask

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Captures the decoder's control bundle, register-file read data, immediate, register specifiers and PC+4 at each clock edge, and presents them to EX.
- Contains the load-use hazard detector. It inserts one bubble per load-use dependency, handles flush from branch/jump resolution and hold from memory, and counts inserted bubbles.

Parameters:
- DATA_W, 32, datapath width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard the ID-stage instruction (taken branch/jump)
- hold  in  1  freeze ID/EX contents (downstream memory stall)
- id_instr  in  32  instruction in ID
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data
- id_R_Ibar_type, id_MemtoReg, id_RegWrite, id_MemWrite, id_MemRead, id_Branch, id_RegDst  in  1 each  decoder controls
- id_Jump, id_ALUSrc, id_branch_type  in  2 each  decoder controls
- id_ALU_ctrl  in  4  decoder ALU select
- ex_* (one per id_* control above, same width)  out  registered controls
- ex_rs_data, ex_rt_data, ex_pc4  out  DATA_W  registered data
- ex_imm  out  16  instr[15:0]
- ex_shamt  out  5  instr[10:6]
- ex_rs, ex_rt, ex_rd  out  5 each  instr[25:21], [20:16], [15:11]
- ex_wreg  out  5  resolved write register
- ex_valid  out  1  EX holds a real instruction
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
- bubble_count  out  CNT_W  load-use bubbles inserted since reset

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0, ex_valid 0, bubble_count 0. The EX state equals a nop bubble. Leaving reset needs no cycle of preparation.
- Write-register resolution is registered at capture:
  - id_Jump==2'b11 gives 31.
  - else id_RegDst==1 gives rt.
  - else rd.
- Load in EX: ex_valid & ex_MemtoReg & ex_RegWrite & (ex_wreg!=0). ex_MemRead is not used for detection.
- ID uses rt when any of these hold:
  - opcode 000000 and funct is not jr (001000);
  - opcode 000100 (beq), 000101 (bne) or 101011 (sw).
- ID uses rs for every opcode except 000010 (j), 000011 (jal) and 001111 (lui). For opcode 000000, rs is not used when funct is sll, srl or sra.
- loaduse = load in EX & ((rs used & ex_wreg==id_rs) | (rt used & ex_wreg==id_rt)).
- hazard_stall = loaduse & ~flush & ~hold.
- Update priority at each rising edge, highest first:
  1. flush: load bubble (all controls 0, ex_valid 0). A flushed cycle never counts as a bubble.
  2. hold: all ex_* and ex_valid keep their value.
  3. loaduse: load bubble; bubble_count increments.
  4. otherwise: capture all id_* fields, ex_valid=1.
- Bubble: every control output 0. Data and specifier outputs may also be 0; EX must ignore them when ex_valid=0.
- One dependency costs exactly one bubble. After the bubble, ex_valid=0, so loaduse drops and the held instruction is captured on the next edge.
- A load followed by a dependent load still produces exactly one bubble.
- bubble_count saturates at 2^CNT_W-1 and does not wrap.
- Latency: one cycle, ID to EX.
- Simultaneous flush and hold: flush wins, and EX becomes a bubble.
- Reset asserted mid-stall: outputs clear immediately. The next instruction after release is captured with no bubble.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ex_RegWrite=1 held → all outputs 0 before the next edge; bubble_count=0.
- Load-use: lw $8,0($9) then add $10,$8,$11 →
  - one cycle with hazard_stall=1;
  - EX shows lw, then a bubble (ex_valid=0), then add with ex_rs=8;
  - bubble_count=1.
- No false stall:
  - lw $8 then lui $8,0x1234 → hazard_stall stays 0.
  - lw $0 then add $1,$0,$0 → hazard_stall stays 0.
- jal write register: jal with id_RegDst=0 → ex_wreg=31, ex_Jump=2'b11. A following lw writing $31 and an add reading $31 stall one cycle.
- Flush priority: flush=1 while a loaduse condition holds →
  - hazard_stall=0;
  - EX becomes a bubble;
  - bubble_count unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles with ori in EX → ex_ALU_ctrl stays 4'b0100 and ex_valid stays 1.
  - With CNT_W=2, 5 load-use pairs → bubble_count=3.
